// File: rtl/nios2_mul_seq_if.sv
// Bundle between the two multiply requesters, the shared 16x16 multiplier cell
// and the sequencer that owns the cell.
interface nios2_mul_seq_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_en;
  logic [31:0] mul_p;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        busy;

  // The sequencer side: accepts requests, drives the cell, returns results.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  mul_p,
    output req0_ready, req1_ready,
    output mul_a, mul_b, mul_en,
    output rsp_valid, rsp_id, rsp_result, busy
  );

  // The environment side: requesters plus the registered multiplier cell.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output mul_p,
    input  req0_ready, req1_ready,
    input  mul_a, mul_b, mul_en,
    input  rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/nios2_mul_seq.sv
// Round-robin sequencer sharing one registered 16x16 multiplier between two
// requesters; builds the low 32 bits of a 32x32 product from three partials.
module nios2_mul_seq #(
  parameter bit ZERO_BYPASS = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  nios2_mul_seq_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_M1,
    S_M2,
    S_M3,
    S_ACC
  } state_t;

  state_t              r_state;
  logic                r_rr_ptr;
  logic                r_id;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_result;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic                r_busy;
  logic                r_mul_en;
  logic [HALF_W-1:0]   r_mul_a;
  logic [HALF_W-1:0]   r_mul_b;

  logic                w_idle;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_accept;
  logic                w_sel_id;
  logic                w_zero;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;

  // Cross partials only contribute their low half, shifted into the upper word.
  function automatic logic [DATA_W-1:0] acc_cross(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] p);
    return acc + {p[HALF_W-1:0], {HALF_W{1'b0}}};
  endfunction

  always_comb begin
    w_idle   = (r_state == S_IDLE) && !reset;
    w_gnt0   = w_idle && bus.req0_valid && (!bus.req1_valid || !r_rr_ptr);
    w_gnt1   = w_idle && bus.req1_valid && (!bus.req0_valid ||  r_rr_ptr);
    w_accept = w_gnt0 || w_gnt1;
    w_sel_id = w_gnt1;
    w_sel_a  = w_gnt1 ? bus.req1_a : bus.req0_a;
    w_sel_b  = w_gnt1 ? bus.req1_b : bus.req0_b;
    w_zero   = ZERO_BYPASS && ((w_sel_a == '0) || (w_sel_b == '0));
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;
  assign bus.mul_en     = r_mul_en;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_result;
  assign bus.busy       = r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 1'b0;
      r_acc       <= '0;
      r_result    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_busy      <= 1'b0;
      r_mul_en    <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        // IDLE: arbitrate, latch operands, issue lo*lo on the next cycle
        S_IDLE: begin
          if (w_accept) begin
            r_rr_ptr <= ~w_sel_id;
            r_id     <= w_sel_id;
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            if (w_zero) begin
              r_rsp_valid <= 1'b1;
              r_rsp_id    <= w_sel_id;
              r_result    <= '0;
            end else begin
              r_state  <= S_M1;
              r_busy   <= 1'b1;
              r_mul_en <= 1'b1;
              r_mul_a  <= w_sel_a[HALF_W-1:0];
              r_mul_b  <= w_sel_b[HALF_W-1:0];
            end
          end
        end
        // M1: lo*lo in flight; queue lo_a*hi_b
        S_M1: begin
          r_state <= S_M2;
          r_mul_a <= r_a[HALF_W-1:0];
          r_mul_b <= r_b[DATA_W-1:HALF_W];
        end
        // M2: lo*lo arrives; queue hi_a*lo_b
        S_M2: begin
          r_state <= S_M3;
          r_acc   <= bus.mul_p;
          r_mul_a <= r_a[DATA_W-1:HALF_W];
          r_mul_b <= r_b[HALF_W-1:0];
        end
        // M3: lo_a*hi_b arrives; release the cell
        S_M3: begin
          r_state  <= S_ACC;
          r_acc    <= acc_cross(r_acc, bus.mul_p);
          r_mul_en <= 1'b0;
          r_mul_a  <= '0;
          r_mul_b  <= '0;
        end
        // ACC: hi_a*lo_b arrives; publish the result
        S_ACC: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_result    <= acc_cross(r_acc, bus.mul_p);
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_mul_en <= 1'b0;
          r_mul_a  <= '0;
          r_mul_b  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nios2_mul_seq.sv
// Directed bench for nios2_mul_seq: scoreboard of expected responses plus
// per-cycle checks of the multiplier-cell issue sequence.
module tb_nios2_mul_seq;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  nios2_mul_seq_if bus0();
  nios2_mul_seq_if bus1();

  nios2_mul_seq #(.ZERO_BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  nios2_mul_seq #(.ZERO_BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Registered multiplier cells: product valid the cycle after mul_en.
  always @(posedge clk) begin
    if (bus0.mul_en) bus0.mul_p <= {16'h0, bus0.mul_a} * {16'h0, bus0.mul_b};
    if (bus1.mul_en) bus1.mul_p <= {16'h0, bus1.mul_a} * {16'h0, bus1.mul_b};
  end

  typedef struct {
    logic        id;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          gid[$];
  int          gtime[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          g_cyc = -100;
  int          gcount = 0;
  logic [31:0] g_a, g_b;
  logic        hold0 = 1'b0, hold1 = 1'b0;
  logic        drop0, drop1;
  logic        s1_r0, s1_r1, s1_vld, s1_id, s1_busy, en1_seen;
  logic [31:0] s1_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic record_grant(input logic id, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id  = id;
    e.res = a * b;
    e.cyc = cyc;
    sb.push_back(e);
    g_cyc = cyc;
    g_a   = a;
    g_b   = b;
    gcount++;
    gid.push_back(int'(id));
    gtime.push_back(cyc);
  endtask

  // One clock: sample mid-cycle, check dut0, snapshot dut1, advance.
  task automatic cycle();
    int          d;
    exp_t        e;
    logic [15:0] ea, eb;
    #4;
    drop0 = 1'b0;
    drop1 = 1'b0;
    chk1("ready_onehot", bus0.req0_ready & bus0.req1_ready, 1'b0);
    if (sb.size() > 0 && sb[0].cyc + 5 == cyc) begin
      e = sb.pop_front();
      chk1("rsp_valid", bus0.rsp_valid, 1'b1);
      chk1("rsp_id", bus0.rsp_id, e.id);
      chk("rsp_result", bus0.rsp_result, e.res);
    end else begin
      chk1("rsp_quiet", bus0.rsp_valid, 1'b0);
    end
    d  = cyc - g_cyc;
    ea = 16'h0;
    eb = 16'h0;
    if (d == 1) begin ea = g_a[15:0];  eb = g_b[15:0];  end
    if (d == 2) begin ea = g_a[15:0];  eb = g_b[31:16]; end
    if (d == 3) begin ea = g_a[31:16]; eb = g_b[15:0];  end
    chk1("mul_en", bus0.mul_en, (d >= 1 && d <= 3));
    chk("mul_a", {16'h0, bus0.mul_a}, {16'h0, ea});
    chk("mul_b", {16'h0, bus0.mul_b}, {16'h0, eb});
    chk1("busy", bus0.busy, (d >= 1 && d <= 4));
    if (bus0.req0_ready) begin
      record_grant(1'b0, bus0.req0_a, bus0.req0_b);
      drop0 = 1'b1;
    end
    if (bus0.req1_ready) begin
      record_grant(1'b1, bus0.req1_a, bus0.req1_b);
      drop1 = 1'b1;
    end
    s1_r0   = bus1.req0_ready;
    s1_r1   = bus1.req1_ready;
    s1_vld  = bus1.rsp_valid;
    s1_id   = bus1.rsp_id;
    s1_res  = bus1.rsp_result;
    s1_busy = bus1.busy;
    if (bus1.mul_en) en1_seen = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    if (drop0 && !hold0) bus0.req0_valid = 1'b0;
    if (drop1 && !hold1) bus0.req1_valid = 1'b0;
  endtask

  task automatic run_until_grants(input int n, input int budget);
    int k = 0;
    while (gcount < n && k < budget) begin
      cycle();
      k++;
    end
    chk("grant_count", gcount, n);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() > 0 && k < budget) begin
      cycle();
      k++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int t0;
    int base;
    reset = 1'b1;
    bus0.req0_valid = 1'b0; bus0.req0_a = '0; bus0.req0_b = '0;
    bus0.req1_valid = 1'b0; bus0.req1_a = '0; bus0.req1_b = '0;
    bus1.req0_valid = 1'b0; bus1.req0_a = '0; bus1.req0_b = '0;
    bus1.req1_valid = 1'b0; bus1.req1_a = '0; bus1.req1_b = '0;
    en1_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk1("rst_busy", bus0.busy, 1'b0);
    chk1("rst_mul_en", bus0.mul_en, 1'b0);
    chk("rst_mul_a", {16'h0, bus0.mul_a}, 32'h0);
    chk("rst_mul_b", {16'h0, bus0.mul_b}, 32'h0);
    chk1("rst_rsp_valid", bus0.rsp_valid, 1'b0);
    chk1("rst_rsp_id", bus0.rsp_id, 1'b0);
    chk("rst_rsp_result", bus0.rsp_result, 32'h0);
    chk1("rst_ready0", bus0.req0_ready, 1'b0);
    chk("rst_dut1_result", bus1.rsp_result, 32'h0);

    // Basic req0 operation, accepted in the first cycle it is offered
    bus0.req0_a = 32'h0001_2345; bus0.req0_b = 32'h0001_0003; bus0.req0_valid = 1'b1;
    t0 = cyc;
    run_until_grants(1, 4);
    chk("t1_grant_cycle", gtime[0], t0);
    drain(10);
    chk("t1_result_hold", bus0.rsp_result, 32'h2348_69CF);

    // req1 with all-ones operands: partial-product wrap
    bus0.req1_a = 32'hFFFF_FFFF; bus0.req1_b = 32'hFFFF_FFFF; bus0.req1_valid = 1'b1;
    run_until_grants(gcount + 1, 4);
    drain(10);
    chk("t2_result_hold", bus0.rsp_result, 32'h0000_0001);
    chk1("t2_id_hold", bus0.rsp_id, 1'b1);

    // Back-to-back: second request accepted in the cycle of the first response
    bus0.req0_a = 32'hDEAD_BEEF; bus0.req0_b = 32'h1234_5678; bus0.req0_valid = 1'b1;
    run_until_grants(gcount + 1, 4);
    bus0.req0_a = 32'h0BAD_F00D; bus0.req0_b = 32'hCAFE_F00D; bus0.req0_valid = 1'b1;
    run_until_grants(gcount + 1, 8);
    chk("b2b_gap", gtime[gtime.size()-1] - gtime[gtime.size()-2], 5);
    drain(12);

    // Zero operand without bypass still takes the full path
    bus0.req0_a = 32'h0; bus0.req0_b = 32'h0000_1234; bus0.req0_valid = 1'b1;
    run_until_grants(gcount + 1, 4);
    drain(10);
    chk("zb0_result", bus0.rsp_result, 32'h0);

    // Both requesters held valid from reset: alternating grants 5 cycles apart
    reset = 1'b1;
    hold0 = 1'b1; hold1 = 1'b1;
    bus0.req0_a = 32'h89AB_CDEF; bus0.req0_b = 32'h0123_4567; bus0.req0_valid = 1'b1;
    bus0.req1_a = 32'h7FFF_8001; bus0.req1_b = 32'h0003_0005; bus0.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc = cyc + 2;
    reset = 1'b0;
    sb.delete();
    g_cyc = -100;
    base = gid.size();
    run_until_grants(gcount + 4, 30);
    bus0.req0_valid = 1'b0; bus0.req1_valid = 1'b0;
    hold0 = 1'b0; hold1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("alt_id", gid[base+k], k % 2);
      if (k > 0) chk("alt_gap", gtime[base+k] - gtime[base+k-1], 5);
    end
    drain(12);

    // Reset during M2 aborts the operation and restores rr_ptr to req0
    bus0.req0_a = 32'h1111_1111; bus0.req0_b = 32'h2222_2222; bus0.req0_valid = 1'b1;
    run_until_grants(gcount + 1, 4);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    sb.delete();
    g_cyc = -100;
    chk1("abort_busy", bus0.busy, 1'b0);
    chk1("abort_mul_en", bus0.mul_en, 1'b0);
    repeat (6) cycle();
    bus0.req0_a = 32'h0000_0003; bus0.req0_b = 32'h0000_0007; bus0.req0_valid = 1'b1;
    bus0.req1_a = 32'h0000_0005; bus0.req1_b = 32'h0000_000B; bus0.req1_valid = 1'b1;
    run_until_grants(gcount + 1, 4);
    chk("abort_rr_id", gid[gid.size()-1], 0);
    run_until_grants(gcount + 1, 8);
    chk("abort_next_id", gid[gid.size()-1], 1);
    drain(12);

    // Bypass instance: a normal op first so a zero result is observable
    bus1.req0_a = 32'h3; bus1.req0_b = 32'h5; bus1.req0_valid = 1'b1;
    cycle();
    chk1("zb1_ready0", s1_r0, 1'b1);
    bus1.req0_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      chk1("zb1_rsp_timing", s1_vld, (k == 5));
    end
    chk("zb1_normal_result", s1_res, 32'd15);
    en1_seen = 1'b0;
    bus1.req1_a = 32'h0; bus1.req1_b = 32'h0000_1234; bus1.req1_valid = 1'b1;
    cycle();
    chk1("zb1_ready1", s1_r1, 1'b1);
    bus1.req1_valid = 1'b0;
    cycle();
    chk1("zb1_rsp_t1", s1_vld, 1'b1);
    chk("zb1_result", s1_res, 32'h0);
    chk1("zb1_id", s1_id, 1'b1);
    chk1("zb1_busy", s1_busy, 1'b0);
    repeat (4) cycle();
    chk1("zb1_single_rsp", s1_vld, 1'b0);
    chk1("zb1_no_mul_en", en1_seen, 1'b0);

    chk("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nios2_mul_seq.md
Name: nios2_mul_seq

Overview:
- Sequencer and arbiter that shares one registered 16x16 unsigned multiplier cell between two requesters.
- Produces the low 32 bits of a 32x32 product by issuing three partial products (lo*lo, lo_a*hi_b, hi_a*lo_b) back-to-back and accumulating them.
- Sits between the CPU multiply/custom-instruction clients and the shared DSP multiplier cell.

Parameters:
- ZERO_BYPASS, 0, when 1, a request with either operand equal to 0 skips the multiplier and responds with result 0.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  32  requester 0 operand A
- req0_b  in  32  requester 0 operand B
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 accepted this cycle
- req1_a  in  32  requester 1 operand A
- req1_b  in  32  requester 1 operand B
- mul_a  out  16  multiplier cell operand A
- mul_b  out  16  multiplier cell operand B
- mul_en  out  1  multiplier cell clock enable
- mul_p  in  32  multiplier cell product; registered, valid the cycle after mul_en=1
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  1  requester index of the result
- rsp_result  out  32  low 32 bits of A*B
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset values: state=IDLE, rr_ptr=0 (req0 favoured), all outputs 0, accumulator 0.
- Reset mid-operation aborts the operation: no rsp_valid is produced and the arbiter returns to IDLE.
- States: IDLE, M1, M2, M3, ACC.
- IDLE, arbitration:
  - req*_ready is combinational and high only in IDLE, for the granted requester.
  - Only one requester wins per cycle.
  - If both are valid, the requester selected by rr_ptr wins; rr_ptr then points to the other requester.
  - If only one is valid, it wins; rr_ptr is set to the other requester.
  - On accept (cycle T), latch operands A and B and the id, then go to M1.
  - If ZERO_BYPASS=1 and A==0 or B==0: remain in IDLE, result=0, rsp_valid at T+1, mul_en stays 0.
- M1 (T+1): mul_a=A[15:0], mul_b=B[15:0], mul_en=1; go to M2.
- M2 (T+2): mul_a=A[15:0], mul_b=B[31:16], mul_en=1; acc<=mul_p (p1); go to M3.
- M3 (T+3): mul_a=A[31:16], mul_b=B[15:0], mul_en=1; acc<=acc+{mul_p[15:0],16'h0}; go to ACC.
- ACC (T+4): mul_en=0; rsp_result<=acc+{mul_p[15:0],16'h0}; rsp_valid<=1; rsp_id<=latched id; go to IDLE.
- Response timing: rsp_valid is high at T+5 for exactly one cycle.
- Throughput: IDLE may accept a new request in that same T+5 cycle, giving one operation per 5 cycles.
- Arithmetic: all adds are modulo 2^32; p2/p3 bits [31:16] are discarded. Only the low product word is produced; there is no signed distinction.
- Idle outputs: mul_a and mul_b are 0 whenever mul_en=0.
- rsp_result holds its value until the next response.
- Requesters must hold valid and operands until ready. A requester dropping valid while not granted is legal and ignored.

Test Plan:
- req0 A=0x00012345, B=0x00010003 -> req0_ready at T; mul_en high for T+1..T+3; rsp_valid at T+5 with rsp_id=0, rsp_result=0x234869CF.
- req1 A=0xFFFFFFFF, B=0xFFFFFFFF -> rsp_result=0x00000001, rsp_id=1 (partial-product wrap).
- req0 and req1 held valid continuously from reset -> grants alternate 0,1,0,1; grants are 5 cycles apart; each rsp_id matches its grant order.
- Reset asserted during M2 -> next cycle state=IDLE, busy=0, mul_en=0; no rsp_valid; rr_ptr=0.
- ZERO_BYPASS=1, A=0, B=0x1234 -> rsp_valid at T+1, result 0, mul_en never asserted. With ZERO_BYPASS=0, the same request takes the full 5-cycle path with result 0.
- Back-to-back: a new req0 is accepted in the same cycle as the previous rsp_valid -> the second rsp_valid arrives exactly 5 cycles later.
